// File: rtl/seg7_pkg.sv
// seg7_pkg: shared digit count, index width and hex segment patterns (active-high gfedcba).
package seg7_pkg;
  localparam int DIGITS = 8;
  localparam int IDX_W = 3;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_HEX [0:15] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };
endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: nibble to active-high gfedcba pattern; SEG7_BLANK_F_EN renders F as blank.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
`ifdef SEG7_BLANK_F_EN
  assign seg = (nib == 4'hF) ? SEG_BLANK : SEG_HEX[nib];
`else
  assign seg = SEG_HEX[nib];
`endif
endmodule

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: 8-digit multiplexed 7-seg scanner with frame-boundary word capture.
// Optional SEG7_BLANK_F_EN (in hex_to_seg7) blanks nibble F.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int CLK_DIV    = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         data_in,
  input  logic                load,
  output logic                frame_tick,
  output logic [DIGITS-1:0]   an,
  output logic [6:0]          seg,
  output logic                dp
);
  localparam int CNT_W = $clog2(CLK_DIV);
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [31:0]       r_disp;
  logic [DIGITS-1:0] r_an;
  logic [6:0]        r_seg;
  logic              w_step;
  logic [3:0]        w_nib;
  logic [6:0]        w_hex;
  assign w_step     = (r_cnt == CNT_W'(CLK_DIV - 1));
  assign frame_tick = w_step && (r_idx == IDX_W'(DIGITS - 1));
  assign w_nib      = r_disp[{r_idx, 2'b00} +: 4];
  hex_to_seg7 u_dec (.nib(w_nib), .seg(w_hex));
  // Output registers hold active-high values; polarity is applied on the way out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_disp <= '0;
      r_an   <= '0;
      r_seg  <= '0;
    end else begin
      r_cnt <= w_step ? '0 : r_cnt + 1'b1;
      if (w_step) r_idx <= r_idx + 1'b1;
      if (frame_tick && load) r_disp <= data_in;
      r_an  <= DIGITS'(1) << r_idx;
      r_seg <= w_hex;
    end
  end
  assign an  = r_an ^ {DIGITS{ACTIVE_LOW}};
  assign seg = r_seg ^ {7{ACTIVE_LOW}};
  assign dp  = ACTIVE_LOW;
endmodule
